// File: rtl/prio_irq_ctrl_if.sv
// Request/grant bundle between peripheral event lines, the consumer FSM and prio_irq_ctrl.
// slave = the controller, master = the side driving requests and acknowledges.
interface prio_irq_ctrl_if #(
  parameter int N = 8
);
  localparam int W  = $clog2(N);
  localparam int CW = $clog2(N + 1);

  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  mask;
  logic          ack;
  logic          valid;
  logic [W-1:0]  idx_out;
  logic [N-1:0]  pending;
  logic [CW-1:0] pend_cnt;

  modport slave (
    input  en, req, mask, ack,
    output valid, idx_out, pending, pend_cnt
  );

  modport master (
    output en, req, mask, ack,
    input  valid, idx_out, pending, pend_cnt
  );
endinterface

// File: rtl/prio_irq_ctrl.sv
// Sticky-pending priority interrupt controller with valid/ack grant handshake.
// Define PRIO_IRQ_CTRL_ROUND_ROBIN_EN for rotating priority; default is fixed (N-1 highest).
module prio_irq_ctrl #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst,
  prio_irq_ctrl_if.slave irq
);
  localparam int W  = $clog2(N);
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] pend_q;
  logic [W-1:0] idx_q;
  logic [N-1:0] elig;
  logic [W-1:0] sel;
  logic         grant;
  logic         ack_hit;
  logic [N-1:0] clr_vec;
  logic [N-1:0] set_vec;

  function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] e);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++)
      if (e[i]) s = W'(i);
    return s;
  endfunction

  function automatic logic [W-1:0] sel_rot(input logic [N-1:0] e, input logic [W-1:0] top);
    logic [W-1:0] s;
    logic         found;
    int           j;
    s     = '0;
    found = 1'b0;
    // Walk downward from the current top-priority line, wrapping 0 -> N-1.
    for (int k = 0; k < N; k++) begin
      j = (int'(top) - k + N) % N;
      if (!found && e[j]) begin
        s     = W'(j);
        found = 1'b1;
      end
    end
    return s;
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++)
      c = c + CW'(v[i]);
    return c;
  endfunction

  assign elig    = pend_q & ~irq.mask;
  assign grant   = (state == IDLE) && irq.en && (|elig);
  assign ack_hit = (state == PRESENT) && irq.ack;
  assign set_vec = irq.en ? irq.req : '0;

  always_comb begin
    clr_vec = '0;
    if (ack_hit) clr_vec[idx_q] = 1'b1;
  end

`ifdef PRIO_IRQ_CTRL_ROUND_ROBIN_EN
  logic [W-1:0] ptr_q;

  assign sel = sel_rot(elig, ptr_q);

  // The line just serviced drops to lowest priority; pointer moves on ack only.
  always_ff @(posedge clk) begin
    if (rst)
      ptr_q <= W'(N - 1);
    else if (ack_hit)
      ptr_q <= W'((int'(idx_q) + N - 1) % N);
  end
`else
  assign sel = sel_fixed(elig);
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (grant)   state_nxt = PRESENT;
      PRESENT: if (irq.ack) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    irq.valid = (state == PRESENT);
  end

  // Set wins over the ack clear, so a line re-raised on the ack edge stays pending.
  always_ff @(posedge clk) begin
    if (rst)
      pend_q <= '0;
    else
      pend_q <= (pend_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst)
      idx_q <= '0;
    else if (grant)
      idx_q <= sel;
  end

  assign irq.idx_out  = idx_q;
  assign irq.pending  = pend_q;
  assign irq.pend_cnt = popcount(pend_q);
endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Directed-vector bench for prio_irq_ctrl (N=8); expectations are hand-computed.
module tb_prio_irq_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  prio_irq_ctrl_if #(.N(8)) bus ();

  prio_irq_ctrl #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .irq (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] idx);
    chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
    if (v) chk({tag, ".idx"}, 32'(bus.idx_out), 32'(idx));
  endtask

  logic [2:0] seq_exp [9];

  initial begin
`ifdef PRIO_IRQ_CTRL_ROUND_ROBIN_EN
    seq_exp = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
`else
    seq_exp = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
`endif
    rst      = 1'b1;
    bus.en   = 1'b1;
    bus.req  = 8'hFF;
    bus.mask = 8'h00;
    bus.ack  = 1'b0;

    // 1. reset dominates latching
    tick();
    tick();
    chk("rst.valid", 32'(bus.valid), 32'd0);
    chk("rst.idx", 32'(bus.idx_out), 32'd0);
    chk("rst.pending", 32'(bus.pending), 32'h00);
    chk("rst.cnt", 32'(bus.pend_cnt), 32'd0);
    rst = 1'b0;
    bus.req = 8'h28;

    // 2. basic grant and clear
    tick();
    bus.req = 8'h00;
    chk("basic.pending", 32'(bus.pending), 32'h28);
    chk("basic.cnt", 32'(bus.pend_cnt), 32'd2);
    chk("basic.nolat", 32'(bus.valid), 32'd0);
    tick();
    chk_out("basic.g5", 1'b1, 3'd5);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("basic.pend08", 32'(bus.pending), 32'h08);
    chk("basic.bubble", 32'(bus.valid), 32'd0);
    tick();
    chk_out("basic.g3", 1'b1, 3'd3);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("basic.pend0", 32'(bus.pending), 32'h00);
    chk("basic.cnt0", 32'(bus.pend_cnt), 32'd0);
    chk("basic.idle", 32'(bus.valid), 32'd0);

    // 3. masking, and mask change while presenting
    bus.req = 8'h28;
    tick();
    bus.req  = 8'h00;
    bus.mask = 8'h20;
    tick();
    chk_out("mask.g3", 1'b1, 3'd3);
    bus.ack = 1'b1;
    tick();
    bus.ack  = 1'b0;
    bus.mask = 8'h00;
    chk("mask.pend20", 32'(bus.pending), 32'h20);
    tick();
    chk_out("mask.g5", 1'b1, 3'd5);
    bus.mask = 8'h20;
    tick();
    tick();
    chk_out("mask.hold5", 1'b1, 3'd5);
    bus.ack = 1'b1;
    tick();
    bus.ack  = 1'b0;
    bus.mask = 8'h00;
    chk("mask.pend0", 32'(bus.pending), 32'h00);

    // 4. enable gating
    bus.en  = 1'b0;
    bus.req = 8'hFF;
    for (int i = 0; i < 5; i++) tick();
    chk("en.pending", 32'(bus.pending), 32'h00);
    chk("en.valid", 32'(bus.valid), 32'd0);
    bus.en  = 1'b1;
    bus.req = 8'h00;
    tick();
    tick();
    chk("en.nogrant", 32'(bus.valid), 32'd0);

    // all lines masked, and a stray ack while idle
    bus.mask = 8'hFF;
    bus.req  = 8'h10;
    tick();
    bus.req = 8'h00;
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    chk("allmask.valid", 32'(bus.valid), 32'd0);
    chk("allmask.pending", 32'(bus.pending), 32'h10);
    chk("allmask.cnt", 32'(bus.pend_cnt), 32'd1);
    bus.mask = 8'h00;
    tick();
    chk_out("allmask.g4", 1'b1, 3'd4);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;

    // 5. en=0 does not retract; set wins over ack clear
    bus.req = 8'h04;
    tick();
    bus.req = 8'h00;
    tick();
    chk_out("sw.g2", 1'b1, 3'd2);
    bus.en = 1'b0;
    tick();
    chk_out("sw.en0hold", 1'b1, 3'd2);
    bus.en  = 1'b1;
    bus.ack = 1'b1;
    bus.req = 8'h04;
    tick();
    bus.ack = 1'b0;
    bus.req = 8'h00;
    chk("sw.pending", 32'(bus.pending), 32'h04);
    chk("sw.bubble", 32'(bus.valid), 32'd0);
    tick();
    chk_out("sw.regrant", 1'b1, 3'd2);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("sw.pend0", 32'(bus.pending), 32'h00);

    // 6. priority mode sequence with all lines held high
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req = 8'hFF;
    tick();
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_out($sformatf("seq%0d", i), 1'b1, seq_exp[i]);
      bus.ack = 1'b1;
      tick();
      bus.ack = 1'b0;
    end
    tick();
    chk_out("seq.again", 1'b1, seq_exp[1]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("seq.rstvalid", 32'(bus.valid), 32'd0);
    chk("seq.rstpend", 32'(bus.pending), 32'h00);
    tick();
    tick();
    chk_out("seq.after_rst", 1'b1, 3'd7);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
